// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] c_PC_INC = 32'd4;
    localparam logic [31:0] c_NOP    = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_if.sv
// ============================================================================
// Module      : ifetch_if
// Description : Instruction SRAM port bundle (fetch unit master, SRAM slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifetch_if #(
    parameter int AW = 10
);
    logic          IMEM_CSN;
    logic          IMEM_WEN;
    logic [AW-1:0] IMEM_A;
    logic [31:0]   IMEM_DI;
    logic [31:0]   IMEM_DOUT;

    modport master (
        output IMEM_CSN,
        output IMEM_WEN,
        output IMEM_A,
        output IMEM_DI,
        input  IMEM_DOUT
    );

    modport slave (
        input  IMEM_CSN,
        input  IMEM_WEN,
        input  IMEM_A,
        input  IMEM_DI,
        output IMEM_DOUT
    );
endinterface

`default_nettype wire

// File: rtl/ifetch_pc_sel.sv
// ============================================================================
// Module      : ifetch_pc_sel
// Description : Next-PC mux, priority reset > redirect > halt > stall > +4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_pc_sel
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        RSTN,
    input  wire logic        REDIRECT_I,
    input  wire logic [31:0] REDIRECT_PC_I,
    input  wire logic        HOLD_I,
    input  wire logic        STALL_I,
    input  wire logic [31:0] PC_Q,
    output logic      [31:0] PC_D
);

    always_comb begin
        PC_D = PC_Q;
        if (!RSTN) begin
            PC_D = RESET_PC;
        end else if (REDIRECT_I) begin
            PC_D = word_align(REDIRECT_PC_I);
        end else if (HOLD_I || STALL_I) begin
            PC_D = PC_Q;
        end else begin
            PC_D = PC_Q + c_PC_INC;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module      : ifetch_unit
// Description : Fetch stage: owns the PC, drives the instruction SRAM and
//               presents {PC, instruction, valid} to decode.
//               Optional perf counters under `IFETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int          AW       = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        CLK,
    input  wire logic        RSTN,
    input  wire logic        STALL_I,
    input  wire logic        REDIRECT_I,
    input  wire logic [31:0] REDIRECT_PC_I,
    input  wire logic        HALT_I,
    ifetch_if.master         IMEM,
    output logic      [31:0] IF_PC_O,
    output logic      [31:0] IF_INST_O,
    output logic             IF_VALID_O,
    output logic      [31:0] PC_O
`ifdef IFETCH_PERF_EN
    ,
    output logic      [31:0] PERF_FETCH_O,
    output logic      [31:0] PERF_BUBBLE_O
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_d;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_d;
    logic [31:0]  r_req_pc;
    logic         r_req_vld;
    logic         w_req_vld_d;
    logic         w_issue;
    logic         w_hold;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_req_vld_d = r_req_vld;
        w_issue     = 1'b0;
        if (REDIRECT_I) begin
            w_state_d   = RUN;
            w_req_vld_d = 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    w_state_d   = RUN;
                    w_req_vld_d = 1'b0;
                end
                RUN: begin
                    if (HALT_I) begin
                        w_state_d   = HALT;
                        w_req_vld_d = 1'b0;
                    end else if (!STALL_I) begin
                        w_req_vld_d = 1'b1;
                        w_issue     = 1'b1;
                    end
                end
                HALT: begin
                    w_req_vld_d = 1'b0;
                end
                default: begin
                    w_state_d   = BOOT;
                    w_req_vld_d = 1'b0;
                end
            endcase
        end
    end

    // Halt in RUN freezes the PC the same way BOOT and HALT do.
    assign w_hold = (r_state != RUN) || HALT_I;

    ifetch_pc_sel #(
        .RESET_PC (RESET_PC)
    ) u_pc_sel (
        .RSTN          (RSTN),
        .REDIRECT_I    (REDIRECT_I),
        .REDIRECT_PC_I (REDIRECT_PC_I),
        .HOLD_I        (w_hold),
        .STALL_I       (STALL_I),
        .PC_Q          (r_pc),
        .PC_D          (w_pc_d)
    );

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_pc      <= RESET_PC;
            r_req_pc  <= 32'h0;
            r_req_vld <= 1'b0;
        end else begin
            r_pc      <= w_pc_d;
            r_req_vld <= w_req_vld_d;
            if (w_issue) begin
                r_req_pc <= r_pc;
            end
        end
    end

    // Chip select is deasserted whenever no new word is wanted so the SRAM holds its output.
    assign IMEM.IMEM_CSN = ~w_issue;
    assign IMEM.IMEM_WEN = 1'b1;
    assign IMEM.IMEM_A   = r_pc[AW+1:2];
    assign IMEM.IMEM_DI  = 32'h0;

    assign IF_PC_O    = r_req_pc;
    assign IF_INST_O  = IMEM.IMEM_DOUT;
    assign IF_VALID_O = r_req_vld;
    assign PC_O       = r_pc;

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_perf_fetch  <= 32'h0;
            r_perf_bubble <= 32'h0;
        end else begin
            if (r_req_vld && !STALL_I) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if ((r_state == RUN) && !r_req_vld) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign PERF_FETCH_O  = r_perf_fetch;
    assign PERF_BUBBLE_O = r_perf_bubble;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Self-checking bench for ifetch_unit with an SRAM model and a
//               cycle-level reference of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

    localparam int          AW       = 7;
    localparam int          WORDS    = 1 << AW;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        STALL_I = 1'b0;
    logic        REDIRECT_I = 1'b0;
    logic [31:0] REDIRECT_PC_I = 32'h0;
    logic        HALT_I = 1'b0;
    logic [31:0] IF_PC_O;
    logic [31:0] IF_INST_O;
    logic        IF_VALID_O;
    logic [31:0] PC_O;
`ifdef IFETCH_PERF_EN
    logic [31:0] PERF_FETCH_O;
    logic [31:0] PERF_BUBBLE_O;
`endif

    ifetch_if #(.AW(AW)) bus ();

    ifetch_unit #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .STALL_I       (STALL_I),
        .REDIRECT_I    (REDIRECT_I),
        .REDIRECT_PC_I (REDIRECT_PC_I),
        .HALT_I        (HALT_I),
        .IMEM          (bus),
        .IF_PC_O       (IF_PC_O),
        .IF_INST_O     (IF_INST_O),
        .IF_VALID_O    (IF_VALID_O),
        .PC_O          (PC_O)
`ifdef IFETCH_PERF_EN
        ,
        .PERF_FETCH_O  (PERF_FETCH_O),
        .PERF_BUBBLE_O (PERF_BUBBLE_O)
`endif
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port SRAM: output only changes on a selected cycle.
    logic [31:0] mem [WORDS];
    always @(posedge CLK) begin
        if (!bus.IMEM_CSN) bus.IMEM_DOUT <= mem[bus.IMEM_A];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: mode 0=boot 1=run 2=halted; next fetch PC; last delivered slot.
    bit          m_known = 0;
    int          m_mode  = 0;
    logic [31:0] m_pc    = 32'h0;
    bit          m_vld   = 0;
    logic [31:0] m_vpc   = 32'h0;
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_bubble = 32'h0;

    function automatic int word_of(input logic [31:0] pc);
        return int'((pc / 4) % WORDS);
    endfunction

    task automatic step(input bit rstn, input bit stall, input bit redir,
                        input logic [31:0] rpc, input bit halt);
        bit exp_csn;
        @(negedge CLK);
        RSTN = rstn; STALL_I = stall; REDIRECT_I = redir;
        REDIRECT_PC_I = rpc; HALT_I = halt;
        #1;
        if (m_known) begin
            exp_csn = !(m_mode == 1 && !stall && !redir && !halt);
            check("imem_csn", {31'b0, bus.IMEM_CSN}, {31'b0, exp_csn});
            if (!exp_csn) check("imem_a", {25'b0, bus.IMEM_A}, word_of(m_pc));
            check("imem_wen", {31'b0, bus.IMEM_WEN}, 32'd1);
            check("imem_di", bus.IMEM_DI, 32'h0);
            check("if_valid", {31'b0, IF_VALID_O}, {31'b0, m_vld});
            if (m_vld || m_mode == 0) check("if_pc", IF_PC_O, m_vpc);
            if (m_vld) check("if_inst", IF_INST_O, mem[word_of(m_vpc)]);
            check("pc_q", PC_O, m_pc);
`ifdef IFETCH_PERF_EN
            check("perf_fetch", PERF_FETCH_O, m_fetch);
            check("perf_bubble", PERF_BUBBLE_O, m_bubble);
`endif
        end
        @(posedge CLK);
        if (!rstn) begin
            m_known = 1; m_mode = 0; m_pc = RESET_PC; m_vld = 0; m_vpc = 32'h0;
            m_fetch = 0; m_bubble = 0;
        end else begin
            if (m_vld && !stall) m_fetch = m_fetch + 1;
            if (m_mode == 1 && !m_vld) m_bubble = m_bubble + 1;
            if (redir) begin
                m_pc = {rpc[31:2], 2'b00}; m_vld = 0; m_mode = 1;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 2) begin
                m_vld = 0;
            end else if (halt) begin
                m_mode = 2; m_vld = 0;
            end else if (!stall) begin
                m_vpc = m_pc; m_vld = 1; m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 32'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
        mem[64] = 32'd64;

        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        run(3);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0, 0);
        run(1);
        step(1, 0, 1, 32'h0000_0103, 0);
        run(3);
        step(1, 1, 1, 32'h0000_0100, 0);
        run(2);
        step(1, 0, 0, 32'h0, 1);
        run(4);
        step(1, 1, 0, 32'h0, 1);
        step(1, 0, 1, 32'h0000_0000, 0);
        run(3);
        step(1, 0, 1, 32'h0000_01FC, 0);
        run(4);
        step(1, 0, 1, 32'hFFFF_FFF8, 0);
        run(4);
        step(0, 0, 0, 32'h0, 0);
        run(2);
        step(1, 1, 0, 32'h0, 1);
        run(2);
        step(1, 0, 1, 32'h0, 0);
        run(2);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) != 0),
                 ($urandom_range(3) == 0),
                 ($urandom_range(11) == 0),
                 $urandom,
                 ($urandom_range(24) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
